// File: rtl/wb_peripheral_bridge_pipelined.sv
// Pipelined Wishbone slave to simple peripheral bus bridge.
// Accepted requests are queued in a small FIFO. A three-state engine then issues
// them one at a time on the peripheral bus, waits while the peripheral reports
// busy (optionally giving up after a timeout), and returns exactly one ack or
// error pulse per request, in the order the requests were accepted.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | no access in flight; start one when the queue has an entry
// S_ACCESS  | head entry driven on the peripheral bus; waiting for busy low
// S_RESPOND | one-cycle ack/error pulse; the completed entry is already popped
module wb_peripheral_bridge_pipelined #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    output logic                    wb_ack_o,
    output logic                    wb_error_o,
    output logic                    wb_stall_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    output logic                    peripheralBus_we,
    output logic                    peripheralBus_oe,
    input  logic                    peripheralBus_busy,
    output logic [ADDR_WIDTH-1:0]   peripheralBus_address,
    output logic [DATA_WIDTH/8-1:0] peripheralBus_byteSelect,
    output logic [DATA_WIDTH-1:0]   peripheralBus_dataWrite,
    input  logic [DATA_WIDTH-1:0]   peripheralBus_dataRead
);

    localparam int SEL_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int ENTRY_W    = 1 + SEL_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    // Counter value at which one more busy cycle means the access has used up
    // its whole budget of TIMEOUT_CYCLES busy cycles.
    localparam logic [TMR_W-1:0] TO_LAST =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [CNT_W-1:0]   fifo_count;
    logic [TMR_W-1:0]   busy_cnt;
    logic               suppress;
    logic               push;
    logic               pop;
    logic               done_ok;
    logic               done_to;
    logic               keep_inflight;
    logic               respond_ok;

    logic                  head_we;
    logic [SEL_WIDTH-1:0]  head_sel;
    logic [ADDR_WIDTH-1:0] head_adr;
    logic [DATA_WIDTH-1:0] head_data;

    assign {head_we, head_sel, head_adr, head_data} = fifo_mem[rd_ptr];

    assign wb_stall_o = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    // A response is only reported if the master kept the cycle open throughout.
    assign respond_ok = wb_cyc_i & ~suppress;

    // Completion decode for the in-flight access; the entry stays in the FIFO
    // until it completes so the stall flag reflects it.
    always_comb begin
        done_ok       = 1'b0;
        done_to       = 1'b0;
        if (state == S_ACCESS) begin
            done_ok = ~peripheralBus_busy;
            done_to = peripheralBus_busy & TIMEOUT_EN & (busy_cnt == TO_LAST);
        end
        pop           = done_ok | done_to;
        rd_ptr_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        keep_inflight = (state == S_ACCESS) & ~pop;
    end

    // Request storage; the payload needs no reset, only the pointers do.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wb_we_i, wb_sel_i, wb_adr_i, wb_data_i};
        end
    end

    // FIFO pointers and occupancy; dropping cyc discards everything except an
    // access that is still running on the peripheral bus.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (!wb_cyc_i) begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= rd_ptr_nxt + PTR_W'(keep_inflight);
            fifo_count <= CNT_W'(keep_inflight);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Access engine with registered peripheral-bus and response outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state                    <= S_IDLE;
            busy_cnt                 <= '0;
            suppress                 <= 1'b0;
            peripheralBus_we         <= 1'b0;
            peripheralBus_oe         <= 1'b0;
            peripheralBus_address    <= '0;
            peripheralBus_byteSelect <= '0;
            peripheralBus_dataWrite  <= '0;
            wb_ack_o                 <= 1'b0;
            wb_error_o               <= 1'b0;
            wb_data_o                <= '1;
        end else begin
            wb_ack_o   <= 1'b0;
            wb_error_o <= 1'b0;
            wb_data_o  <= '1;
            case (state)
                S_IDLE: begin
                    if (fifo_count != '0 && wb_cyc_i) begin
                        state                    <= S_ACCESS;
                        busy_cnt                 <= '0;
                        suppress                 <= 1'b0;
                        peripheralBus_we         <= head_we;
                        peripheralBus_oe         <= ~head_we;
                        peripheralBus_address    <= head_adr;
                        peripheralBus_byteSelect <= head_sel;
                        peripheralBus_dataWrite  <= head_we ? head_data : '0;
                    end
                end
                S_ACCESS: begin
                    if (!wb_cyc_i) begin
                        suppress <= 1'b1;
                    end
                    if (pop) begin
                        state                    <= S_RESPOND;
                        peripheralBus_we         <= 1'b0;
                        peripheralBus_oe         <= 1'b0;
                        peripheralBus_address    <= '0;
                        peripheralBus_byteSelect <= '0;
                        peripheralBus_dataWrite  <= '0;
                        wb_ack_o                 <= done_ok & respond_ok;
                        wb_error_o               <= done_to & respond_ok;
                        if (done_ok && respond_ok && !peripheralBus_we) begin
                            wb_data_o <= peripheralBus_dataRead;
                        end
                    end else if (TIMEOUT_EN) begin
                        busy_cnt <= busy_cnt + TMR_W'(1);
                    end
                end
                S_RESPOND: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_peripheral_bridge_pipelined.sv
// Self-checking bench for wb_peripheral_bridge_pipelined. Two instances share
// the stimulus: "a" uses the default timeout, "b" a timeout of 8 cycles.
module tb_wb_peripheral_bridge_pipelined;

    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 4;
    localparam logic [DW-1:0] ONES = '1;

    typedef struct {
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            acc_e;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we, busy;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w, dr;

    logic          a_ack, a_err, a_stall, a_pwe, a_poe;
    logic [DW-1:0] a_dat, a_pdw;
    logic [AW-1:0] a_padr;
    logic [SW-1:0] a_psel;
    logic          b_ack, b_err, b_stall, b_pwe, b_poe;
    logic [DW-1:0] b_dat, b_pdw;
    logic [AW-1:0] b_padr;
    logic [SW-1:0] b_psel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_peripheral_bridge_pipelined #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(255)
    ) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_data_i(dat_w),
        .wb_ack_o(a_ack), .wb_error_o(a_err), .wb_stall_o(a_stall), .wb_data_o(a_dat),
        .peripheralBus_we(a_pwe), .peripheralBus_oe(a_poe), .peripheralBus_busy(busy),
        .peripheralBus_address(a_padr), .peripheralBus_byteSelect(a_psel),
        .peripheralBus_dataWrite(a_pdw), .peripheralBus_dataRead(dr)
    );

    wb_peripheral_bridge_pipelined #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_data_i(dat_w),
        .wb_ack_o(b_ack), .wb_error_o(b_err), .wb_stall_o(b_stall), .wb_data_o(b_dat),
        .peripheralBus_we(b_pwe), .peripheralBus_oe(b_poe), .peripheralBus_busy(busy),
        .peripheralBus_address(b_padr), .peripheralBus_byteSelect(b_psel),
        .peripheralBus_dataWrite(b_pdw), .peripheralBus_dataRead(dr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
        sel = '0; adr = '0; dat_w = '0; dr = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; busy = 1'b0;
        sel = 4'hF; adr = 24'h123; dat_w = 32'h1; dr = 32'h55;
        step();
        step();
        checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", a_ack); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_err); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
        checks++; if (a_dat !== ONES) begin errors++; $display("FAIL reset_data: got %h expected %h", a_dat, ONES); end
        checks++;
        if ({a_pwe, a_poe, a_padr, a_psel, a_pdw} !== '0) begin
            errors++; $display("FAIL reset_bus: got we=%b oe=%b adr=%h sel=%h dw=%h expected all zero",
                               a_pwe, a_poe, a_padr, a_psel, a_pdw);
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000010; dat_w = 32'hDEADBEEF; sel = 4'hF; busy = 1'b0;
        step();
        stb = 1'b0; we = 1'b0;
        checks++; if (a_pwe !== 1'b0 || a_ack !== 1'b0) begin errors++; $display("FAIL wr_e0: got we=%b ack=%b expected 0 0", a_pwe, a_ack); end
        step();
        checks++;
        if ({a_pwe, a_poe, a_padr, a_psel, a_pdw, a_ack} !== {1'b1, 1'b0, 24'h000010, 4'hF, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL wr_access: got we=%b oe=%b adr=%h sel=%h dw=%h ack=%b expected 1 0 000010 f deadbeef 0",
                               a_pwe, a_poe, a_padr, a_psel, a_pdw, a_ack);
        end
        step();
        checks++;
        if ({a_ack, a_err, a_pwe, a_dat} !== {1'b1, 1'b0, 1'b0, ONES}) begin
            errors++; $display("FAIL wr_ack: got ack=%b err=%b we=%b dat=%h expected 1 0 0 ffffffff", a_ack, a_err, a_pwe, a_dat);
        end
        step();
        checks++; if (a_ack !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got ack=%b err=%b expected 0 0", a_ack, a_err); end
    endtask

    task automatic test_read_wait();
        int oe_cnt = 0;
        bit got = 0;
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000020; sel = 4'hF; busy = 1'b1; dr = 32'h12345678;
        step();
        stb = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (a_poe) begin
                oe_cnt++;
                if (oe_cnt == 1) begin
                    checks++; if (a_padr !== 24'h000020) begin errors++; $display("FAIL rd_addr: got %h expected 000020", a_padr); end
                end
                if (oe_cnt == 4) busy = 1'b0;
            end
            if (a_ack) begin
                got = 1;
                checks++; if (a_dat !== 32'h12345678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", a_dat); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rd_ack_timeout: got no ack expected ack"); end
        checks++; if (oe_cnt != 4) begin errors++; $display("FAIL rd_oe_cycles: got %0d expected 4", oe_cnt); end
        step();
        checks++; if (a_dat !== ONES || a_ack !== 1'b0) begin errors++; $display("FAIL rd_after: got dat=%h ack=%b expected ffffffff 0", a_dat, a_ack); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, issued = 0, acks = 0;
        int first_ack_t = -1, last_ack_t = -1, fifth_t = -1;
        bit stall_seen = 0;
        logic stall_b, prev_pwe;
        do_reset();
        cyc = 1'b1;
        for (int t = 0; t < 80 && acks < 5; t++) begin
            busy = (t < 10);
            stb = (sent < 5);
            we = 1'b1; sel = 4'hF; adr = 24'(sent * 4); dat_w = 32'hA000_0000 + 32'(sent);
            stall_b = a_stall;
            prev_pwe = a_pwe;
            if (stall_b && sent < 4) begin
                errors++; $display("FAIL b2b_early_stall: got stall=1 with %0d queued expected 0", sent);
            end
            if (stall_b && sent == 4) stall_seen = 1;
            step();
            if (stb && !stall_b) begin
                if (sent == 4) fifth_t = t;
                sent++;
            end
            if (a_pwe && !prev_pwe) begin
                checks++;
                if (a_padr !== 24'(issued * 4)) begin errors++; $display("FAIL b2b_order: got adr %h expected %h", a_padr, 24'(issued * 4)); end
                issued++;
            end
            if (a_err) begin errors++; $display("FAIL b2b_error: got error=1 expected 0"); end
            if (a_ack) begin
                if (acks == 0) first_ack_t = t;
                else begin
                    checks++; if (t - last_ack_t != 3) begin errors++; $display("FAIL b2b_throughput: got gap %0d expected 3", t - last_ack_t); end
                end
                last_ack_t = t;
                acks++;
            end
        end
        stb = 1'b0;
        checks++; if (acks != 5) begin errors++; $display("FAIL b2b_acks: got %0d expected 5", acks); end
        checks++; if (issued != 5) begin errors++; $display("FAIL b2b_issued: got %0d expected 5", issued); end
        checks++; if (!stall_seen) begin errors++; $display("FAIL b2b_stall: got no stall with 4 queued expected stall"); end
        checks++; if (fifth_t != first_ack_t + 1) begin errors++; $display("FAIL b2b_fifth: got accept t=%0d expected %0d", fifth_t, first_ack_t + 1); end
    endtask

    task automatic test_timeout();
        int oe_cnt = 0;
        bit seen = 0, got = 0, wr_ok = 0;
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000030; sel = 4'hF; busy = 1'b1; dr = 32'h0BAD0BAD;
        step();
        we = 1'b1; adr = 24'h000034; dat_w = 32'hCAFEF00D;
        step();
        stb = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (b_poe) oe_cnt++;
            if (b_ack) begin errors++; $display("FAIL to_ack: got ack during timed-out read expected none"); end
            if (b_err) seen = 1;
            else step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_error: got no error expected error"); end
        checks++; if (oe_cnt != 8) begin errors++; $display("FAIL to_busy_cycles: got %0d expected 8", oe_cnt); end
        checks++; if (b_dat !== ONES || b_ack !== 1'b0) begin errors++; $display("FAIL to_data: got dat=%h ack=%b expected ffffffff 0", b_dat, b_ack); end
        busy = 1'b0;
        step();
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got err=%b expected 0", b_err); end
        for (int i = 0; i < 10 && !got; i++) begin
            if (b_pwe && b_padr === 24'h000034 && b_pdw === 32'hCAFEF00D) wr_ok = 1;
            if (b_err) begin errors++; $display("FAIL to_next_err: got error on second request expected ack"); end
            if (b_ack) got = 1;
            else step();
        end
        checks++; if (!wr_ok) begin errors++; $display("FAIL to_next_issue: got no write to 000034 expected one"); end
        checks++; if (!got) begin errors++; $display("FAIL to_next_ack: got no ack expected ack"); end
    endtask

    task automatic test_cyc_drop();
        int oe_cnt = 0, stray = 0, bad = 0;
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; busy = 1'b1; dr = 32'h11112222;
        for (int i = 0; i < 3; i++) begin
            adr = 24'(32'h100 + i * 4);
            step();
        end
        checks++; if (a_poe !== 1'b1 || a_padr !== 24'h000100) begin errors++; $display("FAIL drop_first: got oe=%b adr=%h expected 1 000100", a_poe, a_padr); end
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_poe) oe_cnt++;
            if (a_ack || a_err) bad++;
        end
        checks++; if (oe_cnt != 5) begin errors++; $display("FAIL drop_inflight: got oe for %0d cycles expected 5", oe_cnt); end
        busy = 1'b0;
        step();
        if (a_ack || a_err) bad++;
        cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_ack || a_err) bad++;
            if (a_poe || a_pwe) stray++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL drop_responses: got %0d ack/err cycles expected 0", bad); end
        checks++; if (stray != 0) begin errors++; $display("FAIL drop_flush: got %0d access cycles expected 0", stray); end
        stb = 1'b1; we = 1'b0; adr = 24'h000200; dr = 32'hA5A5C3C3;
        step();
        stb = 1'b0;
        step();
        checks++; if (a_poe !== 1'b1 || a_padr !== 24'h000200) begin errors++; $display("FAIL drop_next_issue: got oe=%b adr=%h expected 1 000200", a_poe, a_padr); end
        step();
        checks++; if (a_ack !== 1'b1 || a_dat !== 32'hA5A5C3C3) begin errors++; $display("FAIL drop_next_ack: got ack=%b dat=%h expected 1 a5a5c3c3", a_ack, a_dat); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd_val;
        do_reset();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'h000040; sel = 4'hF; busy = 1'b1;
        step();
        stb = 1'b0;
        step();
        step();
        checks++; if (a_poe !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got oe=%b expected 1", a_poe); end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_poe, a_pwe, a_padr, a_ack, a_err, a_stall} !== '0) begin
            errors++; $display("FAIL rstmid_async: got oe=%b we=%b adr=%h ack=%b err=%b stall=%b expected all 0",
                               a_poe, a_pwe, a_padr, a_ack, a_err, a_stall);
        end
        step();
        step();
        rst = 1'b0; busy = 1'b0;
        step();
        checks++; if (a_ack || a_err || a_poe) begin errors++; $display("FAIL rstmid_idle: got ack=%b err=%b oe=%b expected 0 0 0", a_ack, a_err, a_poe); end
        rd_val = $urandom;
        dr = rd_val; stb = 1'b1; we = 1'b0; adr = 24'h000044;
        step();
        stb = 1'b0;
        step();
        checks++; if (a_poe !== 1'b1 || a_padr !== 24'h000044) begin errors++; $display("FAIL rstmid_issue: got oe=%b adr=%h expected 1 000044", a_poe, a_padr); end
        step();
        checks++; if (a_ack !== 1'b1 || a_dat !== rd_val) begin errors++; $display("FAIL rstmid_ack: got ack=%b dat=%h expected 1 %h", a_ack, a_dat, rd_val); end
    endtask

    // Transaction-level reference: requests queue in acceptance order, one is
    // issued no earlier than the edge after it was accepted and two edges after
    // the previous completion, and it completes at the first later edge with
    // busy low, answering with the read data present at that edge.
    task automatic test_random();
        req_t q[$];
        req_t cur;
        bit active = 0;
        int last_comp = -10;
        int n_acc = 0, n_ack = 0;
        bit exp_stall, exp_ack;
        logic [DW-1:0] exp_dat;
        logic [1+1+AW+SW+DW-1:0] exp_bus;
        do_reset();
        cyc = 1'b1;
        cur = '{1'b0, '0, '0, '0, 0};
        for (int e = 0; e < 300; e++) begin
            bit drive;
            drive = (e < 260);
            stb = drive && ($urandom_range(0, 9) < 7);
            we = 1'($urandom_range(0, 1));
            sel = 4'($urandom); adr = 24'($urandom); dat_w = $urandom;
            busy = drive && ($urandom_range(0, 9) < 5);
            dr = $urandom;
            exp_stall = ((q.size() + int'(active)) == DEPTH);
            checks++; if (a_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall e=%0d: got %b expected %b", e, a_stall, exp_stall); end
            exp_ack = 0; exp_dat = ONES;
            if (active) begin
                if (!busy) begin
                    exp_ack = 1;
                    exp_dat = cur.we ? ONES : dr;
                    active = 0;
                    last_comp = e;
                end
            end else if (q.size() > 0 && q[0].acc_e < e && e >= last_comp + 2) begin
                cur = q.pop_front();
                active = 1;
            end
            if (stb && !exp_stall) begin
                q.push_back('{we, sel, adr, dat_w, e});
                n_acc++;
            end
            exp_bus = active ? {cur.we, ~cur.we, cur.adr, cur.sel, (cur.we ? cur.dat : 32'h0)} : '0;
            step();
            checks++; if (a_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack e=%0d: got %b expected %b", e, a_ack, exp_ack); end
            checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rnd_err e=%0d: got %b expected 0", e, a_err); end
            checks++; if (a_dat !== exp_dat) begin errors++; $display("FAIL rnd_data e=%0d: got %h expected %h", e, a_dat, exp_dat); end
            checks++;
            if ({a_pwe, a_poe, a_padr, a_psel, a_pdw} !== exp_bus) begin
                errors++; $display("FAIL rnd_bus e=%0d: got %h expected %h", e, {a_pwe, a_poe, a_padr, a_psel, a_pdw}, exp_bus);
            end
            if (a_ack) n_ack++;
        end
        checks++; if (n_ack != n_acc) begin errors++; $display("FAIL rnd_count: got %0d acks expected %0d", n_ack, n_acc); end
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; busy = 1'b0;
        sel = '0; adr = '0; dat_w = '0; dr = '0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_cyc_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion within time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
